// File: rtl/eeg_decimator_framer.sv
// Decimates the filtered EEG stream, keeping one sample in DECIM, buffers kept samples in a FIFO,
// and emits them on a valid/ready stream with a last flag closing every FRAME_LEN-sample epoch.
module eeg_decimator_framer #(
  parameter int DATA_WIDTH = 16,
  parameter int DECIM      = 4,
  parameter int FRAME_LEN  = 256,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          clear,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          in_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(FRAME_LEN);

  localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(FRAME_LEN - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [AW-1:0]         wr_ptr_r, wr_ptr_next_s;
  logic [AW-1:0]         rd_ptr_r, rd_ptr_next_s;
  logic [LW-1:0]         level_r, level_next_s, remain_s;
  logic [PW-1:0]         phase_r, phase_next_s;
  logic [CW-1:0]         count_r, count_next_s;
  logic                  overflow_r, overflow_next_s;
  logic                  out_valid_r, out_valid_next_s;
  logic                  out_last_r, out_last_next_s;
  logic [DATA_WIDTH-1:0] out_data_r, out_data_next_s;

  logic                  keep_s, pop_s, full_s, push_s, drop_s;

  // Handshake decode: which sample is kept, and whether it is pushed or dropped.
  always_comb begin
    keep_s   = in_valid && (phase_r == {PW{1'b0}}) && !clear;
    pop_s    = out_valid_r && out_ready && !clear;
    full_s   = (level_r == LEVEL_FULL);
    push_s   = keep_s && (!full_s || pop_s);
    drop_s   = keep_s && full_s && !pop_s;
    remain_s = level_r - LW'(pop_s);
  end

  // Next-state for counters, pointers and flags; clear overrides push and pop.
  always_comb begin
    phase_next_s    = phase_r;
    count_next_s    = count_r;
    overflow_next_s = overflow_r;
    wr_ptr_next_s   = wr_ptr_r;
    rd_ptr_next_s   = rd_ptr_r;
    level_next_s    = level_r;
    if (clear) begin
      phase_next_s    = {PW{1'b0}};
      count_next_s    = {CW{1'b0}};
      overflow_next_s = 1'b0;
      wr_ptr_next_s   = {AW{1'b0}};
      rd_ptr_next_s   = {AW{1'b0}};
      level_next_s    = {LW{1'b0}};
    end else begin
      if (in_valid) begin
        phase_next_s = (phase_r == PHASE_LAST) ? {PW{1'b0}} : phase_r + PW'(1'b1);
      end else begin
        phase_next_s = phase_r;
      end
      if (pop_s) begin
        count_next_s  = (count_r == COUNT_LAST) ? {CW{1'b0}} : count_r + CW'(1'b1);
        rd_ptr_next_s = rd_ptr_r + AW'(1'b1);
      end else begin
        count_next_s  = count_r;
        rd_ptr_next_s = rd_ptr_r;
      end
      if (push_s) begin
        wr_ptr_next_s = wr_ptr_r + AW'(1'b1);
      end else begin
        wr_ptr_next_s = wr_ptr_r;
      end
      if (drop_s) begin
        overflow_next_s = 1'b1;
      end else begin
        overflow_next_s = overflow_r;
      end
      level_next_s = remain_s + LW'(push_s);
    end
  end

  // Output stage: next head comes from the bypassed input when the queue held only the popped entry.
  always_comb begin
    out_valid_next_s = (level_next_s != {LW{1'b0}});
    out_last_next_s  = out_valid_next_s && (count_next_s == COUNT_LAST);
    if (!out_valid_next_s) begin
      out_data_next_s = out_data_r;
    end else if (remain_s == {LW{1'b0}}) begin
      out_data_next_s = data_in;
    end else begin
      out_data_next_s = mem[rd_ptr_next_s];
    end
  end

  // Sample storage; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem[wr_ptr_r] <= data_in;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      level_r     <= {LW{1'b0}};
      phase_r     <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      overflow_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      wr_ptr_r    <= wr_ptr_next_s;
      rd_ptr_r    <= rd_ptr_next_s;
      level_r     <= level_next_s;
      phase_r     <= phase_next_s;
      count_r     <= count_next_s;
      overflow_r  <= overflow_next_s;
      out_valid_r <= out_valid_next_s;
      out_last_r  <= out_last_next_s;
      out_data_r  <= out_data_next_s;
    end
  end

  assign out_data   = out_data_r;
  assign out_valid  = out_valid_r;
  assign out_last   = out_last_r;
  assign overflow   = overflow_r;
  assign fifo_level = level_r;

endmodule
